// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the CPU datapath and a
// word-addressed data memory. Byte and halfword stores use read-modify-write.
// Loads extract one lane and sign- or zero-extend it.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// halfword/word accesses are rejected with err. When it is undefined, the low
// address bits are forced aligned.
module mem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [29:0]       Address,
    output logic [31:0]       Write_data,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [31:0]       Read_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state, state_nx;

    logic        we_q, sgn_q, err_q;
    logic [1:0]  off_q, size_q;
    logic [31:0] wdata_q;

    logic        req_word, req_half, misalign, trap;
    logic [1:0]  req_off;
    logic [29:0] req_word_addr;

    logic [4:0]  shamt;
    logic [31:0] lane_mask, lane, load_val, merged;
    logic        lane_top;

    // Classify the incoming request: size, aligned lane offset, word address.
    always_comb begin
        req_word      = req_size[1];                 // 11 behaves like 10
        req_half      = (req_size == 2'b01);
        misalign      = (req_half && req_addr[0]) || (req_word && (req_addr[1:0] != 2'b00));
        req_off       = req_word ? 2'b00 : (req_half ? {req_addr[1], 1'b0} : req_addr[1:0]);
        req_word_addr = 30'(req_addr >> 2);
`ifdef MISALIGN_TRAP_EN
        trap          = misalign;
`else
        trap          = 1'b0;
`endif
    end

    // Lane position, extraction/extension for loads and merge for sub-word stores.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave
        // it unassigned and infer a latch.
        shamt     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
        lane_top  = 1'b0;
        case (size_q)
            2'b00: begin
                shamt     = BIG_ENDIAN ? {~off_q, 3'b000} : {off_q, 3'b000};
                lane_mask = 32'h0000_00FF;
            end
            2'b01: begin
                shamt     = BIG_ENDIAN ? {~off_q[1], 4'b0000} : {off_q[1], 4'b0000};
                lane_mask = 32'h0000_FFFF;
            end
            default: ;
        endcase
        lane = (Read_data >> shamt) & lane_mask;
        case (size_q)
            2'b00:   lane_top = lane[7];
            2'b01:   lane_top = lane[15];
            default: lane_top = 1'b0;
        endcase
        load_val = lane | ((sgn_q && lane_top) ? ~lane_mask : 32'h0);
        merged   = (Read_data & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req) begin
                if (trap)                 state_nx = DONE;
                else if (req_we && req_word) state_nx = WR;
                else                      state_nx = RD;
            end
            RD:      state_nx = we_q ? WR : DONE;
            WR:      state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Request latch, memory-side address/data, load result and error flag.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: all datapath registers are reset, so the memory-facing outputs
        // are defined zeros the instant reset asserts.
        if (reset) begin
            we_q       <= 1'b0;
            sgn_q      <= 1'b0;
            err_q      <= 1'b0;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            wdata_q    <= 32'h0;
            Address    <= 30'h0;
            Write_data <= 32'h0;
            rdata      <= 32'h0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    we_q    <= req_we;
                    sgn_q   <= req_signed;
                    err_q   <= trap;
                    off_q   <= req_off;
                    size_q  <= req_word ? 2'b10 : req_size;
                    wdata_q <= req_wdata;
                    if (!trap) Address <= req_word_addr;
                    if (!trap && req_we && req_word) Write_data <= req_wdata;
                end
                RD: begin
                    if (we_q) Write_data <= merged;
                    else      rdata      <= load_val;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign err      = done && err_q;
    assign MemRead  = (state == RD);
    assign MemWrite = (state == WR);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (default parameters).
// A small word memory model answers reads combinationally and commits writes
// on the clock edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, req_we, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        busy, done, err, MemRead, MemWrite;
    logic [31:0] rdata, Write_data, Read_data;
    logic [29:0] Address;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    int          lat, nrd, nwr;
    logic        err_seen;
    logic [29:0] last_addr;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data)
    );

    assign Read_data = (MemRead && Address < 30'd64) ? mem[Address[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (MemWrite && Address < 30'd64) mem[Address[5:0]] <= Write_data;
        else if (pl_en)                   mem[pl_idx]       <= pl_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one request, then scramble the inputs and watch until done.
    // Returns at the falling edge where done is high.
    task automatic run(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wd);
        @(negedge clk);
        req = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_signed = sgn; req_wdata = wd;
        @(posedge clk);
        #1;
        req = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_size = 2'b11;
        req_signed = ~sgn; req_wdata = 32'h5A5A_5A5A;
        lat = 0; nrd = 0; nwr = 0; err_seen = 1'b0; last_addr = '1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (MemRead) begin nrd++; last_addr = Address; end
            if (MemWrite) nwr++;
            if (done) begin lat = i; err_seen = err; break; end
        end
    endtask

    initial begin
        int wr_after;
        reset = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_signed = 1'b0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {31'b0, busy},     32'h0);
        check("rst_done",  {31'b0, done},     32'h0);
        check("rst_err",   {31'b0, err},      32'h0);
        check("rst_mrd",   {31'b0, MemRead},  32'h0);
        check("rst_mwr",   {31'b0, MemWrite}, 32'h0);
        check("rst_rdata", rdata,             32'h0);
        check("rst_addr",  {2'b0, Address},   32'h0);
        check("rst_wdata", Write_data,        32'h0);
        @(negedge clk);
        reset = 1'b0;

        preload(6'd16, 32'hDEAD_BEEF);
        preload(6'd17, 32'h80FF_7F01);
        preload(6'd19, 32'h1122_3344);
        preload(6'd20, 32'h1122_3344);
        preload(6'd21, 32'h5566_7788);

        // Word load at 0x40.
        run(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
        check("wl_lat",   lat,             32'd2);
        check("wl_nrd",   nrd,             32'd1);
        check("wl_nwr",   nwr,             32'd0);
        check("wl_addr",  {2'b0, last_addr}, 32'd16);
        check("wl_rdata", rdata,           32'hDEAD_BEEF);
        check("wl_err",   {31'b0, err_seen}, 32'h0);

        // Byte/half loads from word 17 = 0x80FF7F01.
        run(1'b0, 32'h47, 2'b00, 1'b1, 32'h0);
        check("lb_s",  rdata, 32'hFFFF_FF80);
        run(1'b0, 32'h47, 2'b00, 1'b0, 32'h0);
        check("lb_u",  rdata, 32'h0000_0080);
        run(1'b0, 32'h46, 2'b01, 1'b1, 32'h0);
        check("lh_s",  rdata, 32'hFFFF_80FF);
        run(1'b0, 32'h45, 2'b00, 1'b0, 32'h0);
        check("lb_u1", rdata, 32'h0000_007F);
        run(1'b0, 32'h44, 2'b01, 1'b1, 32'h0);
        check("lh_s0", rdata, 32'h0000_7F01);

        // Byte store 0xAB at 0x4D over 0x11223344.
        run(1'b1, 32'h4D, 2'b00, 1'b0, 32'hFFFF_FFAB);
        check("sb_lat",  lat,   32'd3);
        check("sb_nrd",  nrd,   32'd1);
        check("sb_nwr",  nwr,   32'd1);
        check("sb_wdat", Write_data, 32'h1122_AB44);
        @(negedge clk);
        check("sb_mem",  mem[19], 32'h1122_AB44);

        // Halfword store 0xBEEF at 0x52, then a req raised during DONE.
        run(1'b1, 32'h52, 2'b01, 1'b0, 32'h0000_BEEF);
        check("sh_lat", lat, 32'd3);
        req = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_size = 2'b10;
        req_signed = 1'b0; req_wdata = '0;
        @(negedge clk);
        check("done_req_ignored", {31'b0, busy}, 32'h0);
        check("sh_mem", mem[20], 32'hBEEF_3344);
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("next_acc_mrd",  {31'b0, MemRead}, 32'h1);
        check("next_acc_addr", {2'b0, Address},  32'd16);
        @(negedge clk);
        check("next_acc_done",  {31'b0, done}, 32'h1);
        check("next_acc_rdata", rdata,          32'hDEAD_BEEF);

        // Word store, no read phase.
        run(1'b1, 32'h48, 2'b10, 1'b0, 32'hCAFE_F00D);
        check("sw_lat", lat, 32'd2);
        check("sw_nrd", nrd, 32'd0);
        check("sw_nwr", nwr, 32'd1);
        @(negedge clk);
        check("sw_mem", mem[18], 32'hCAFE_F00D);

        // Reserved size behaves as word.
        run(1'b0, 32'h48, 2'b11, 1'b1, 32'h0);
        check("rsv_rdata", rdata, 32'hCAFE_F00D);

        // Misaligned word load at 0x42.
        run(1'b0, 32'h42, 2'b10, 1'b0, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("mis_lat",   lat,              32'd1);
        check("mis_err",   {31'b0, err_seen}, 32'h1);
        check("mis_nrd",   nrd,              32'd0);
        check("mis_rdata", rdata,            32'hCAFE_F00D);
`else
        check("mis_lat",   lat,              32'd2);
        check("mis_err",   {31'b0, err_seen}, 32'h0);
        check("mis_addr",  {2'b0, last_addr}, 32'd16);
        check("mis_rdata", rdata,            32'hDEAD_BEEF);
`endif

        // Reset asserted during WR of a byte store to word 21.
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_addr = 32'h55; req_size = 2'b00;
        req_signed = 1'b0; req_wdata = 32'h0000_00EE;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rw_in_wr", {31'b0, MemWrite}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rw_mwr",   {31'b0, MemWrite}, 32'h0);
        check("rw_busy",  {31'b0, busy},     32'h0);
        check("rw_addr",  {2'b0, Address},   32'h0);
        check("rw_wdata", Write_data,        32'h0);
        check("rw_rdata", rdata,             32'h0);
        wr_after = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (MemWrite) wr_after++;
        end
        check("rw_no_write", wr_after, 32'd0);
        check("rw_mem",      mem[21],  32'h5566_7788);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
